// File: rtl/ir_transmitter.sv
// NEC IR transmitter: sends leader, addr/~addr/cmd/~cmd (LSB first) and stop mark from a 16-bit code.
// Outputs are registered; the LED is driven by the 38 kHz carrier gated with the mark envelope.
module ir_transmitter #(
  parameter int UNIT_CYCLES  = 28125,
  parameter int CARRIER_HALF = 658
) (
  input  logic        osc_clk,
  input  logic        reset,
  input  logic [15:0] tx_data,
  input  logic        tx_start,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        ir_envelope,
  output logic        ir_led
);

  localparam int UW = $clog2(UNIT_CYCLES);
  localparam int CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
  localparam logic [UW-1:0] UNIT_MAX = UW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] CARR_MAX = CW'(CARRIER_HALF - 1);

  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK
  } state_t;

  state_t        state, state_nxt;
  logic [UW-1:0] unit_cyc, unit_cyc_nxt;
  logic [4:0]    unit_cnt, unit_cnt_nxt, last_unit;
  logic [4:0]    bit_idx, bit_idx_nxt;
  logic [31:0]   shift, shift_nxt;
  logic [CW-1:0] carr_cnt, carr_cnt_nxt;
  logic          carr_ph, carr_ph_nxt;
  logic          unit_end, state_end, mark_now, mark_nxt, done_nxt;

  // Index of the final unit of the current state (duration minus one).
  always_comb begin
    last_unit = 5'd0;
    case (state)
      LEAD_MARK:  last_unit = 5'd15;
      LEAD_SPACE: last_unit = 5'd7;
      BIT_SPACE:  last_unit = shift[0] ? 5'd2 : 5'd0;
      default:    last_unit = 5'd0;
    endcase
  end

  assign unit_end  = (unit_cyc == UNIT_MAX);
  assign state_end = unit_end && (unit_cnt == last_unit);

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    bit_idx_nxt = bit_idx;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (tx_start) begin
          state_nxt   = LEAD_MARK;
          shift_nxt   = {~tx_data[7:0], tx_data[7:0], ~tx_data[15:8], tx_data[15:8]};
          bit_idx_nxt = 5'd0;
        end
      end
      LEAD_MARK:  if (state_end) state_nxt = LEAD_SPACE;
      LEAD_SPACE: if (state_end) state_nxt = BIT_MARK;
      BIT_MARK:   if (state_end) state_nxt = BIT_SPACE;
      BIT_SPACE: begin
        if (state_end) begin
          shift_nxt   = {1'b0, shift[31:1]};
          bit_idx_nxt = bit_idx + 5'd1;
          state_nxt   = (bit_idx == 5'd31) ? STOP_MARK : BIT_MARK;
        end
      end
      STOP_MARK: begin
        if (state_end) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    unit_cyc_nxt = '0;
    unit_cnt_nxt = '0;
    if (state != IDLE && !state_end) begin
      unit_cyc_nxt = unit_end ? '0 : unit_cyc + UW'(1);
      unit_cnt_nxt = unit_end ? unit_cnt + 5'd1 : unit_cnt;
    end
  end

  assign mark_now = (state == LEAD_MARK) || (state == BIT_MARK) || (state == STOP_MARK);
  assign mark_nxt = (state_nxt == LEAD_MARK) || (state_nxt == BIT_MARK) || (state_nxt == STOP_MARK);

  // Marks never follow marks, so entering a mark always restarts the carrier high.
  always_comb begin
    carr_cnt_nxt = '0;
    carr_ph_nxt  = 1'b0;
    if (mark_nxt) begin
      if (!mark_now) begin
        carr_ph_nxt = 1'b1;
      end else if (carr_cnt == CARR_MAX) begin
        carr_ph_nxt = ~carr_ph;
      end else begin
        carr_cnt_nxt = carr_cnt + CW'(1);
        carr_ph_nxt  = carr_ph;
      end
    end
  end

  always_ff @(posedge osc_clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge osc_clk or negedge reset) begin
    if (!reset) begin
      unit_cyc    <= '0;
      unit_cnt    <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      carr_cnt    <= '0;
      carr_ph     <= 1'b0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      ir_envelope <= 1'b0;
      ir_led      <= 1'b0;
    end else begin
      unit_cyc    <= unit_cyc_nxt;
      unit_cnt    <= unit_cnt_nxt;
      bit_idx     <= bit_idx_nxt;
      shift       <= shift_nxt;
      carr_cnt    <= carr_cnt_nxt;
      carr_ph     <= carr_ph_nxt;
      tx_busy     <= (state_nxt != IDLE);
      tx_done     <= done_nxt;
      ir_envelope <= mark_nxt;
      ir_led      <= mark_nxt & carr_ph_nxt;
    end
  end

endmodule

// File: tb/tb_ir_transmitter.sv
// Bench for ir_transmitter: stimulus queues expected codes; a monitor decodes the envelope
// into mark/space runs and compares each finished frame against the queued code.
module tb_ir_transmitter;

  localparam int U  = 4;
  localparam int CH = 1;

  logic        osc_clk;
  logic        reset;
  logic [15:0] tx_data;
  logic        tx_start;
  logic        tx_busy, tx_done, ir_envelope, ir_led;

  ir_transmitter #(.UNIT_CYCLES(U), .CARRIER_HALF(CH)) dut (
    .osc_clk(osc_clk), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .tx_done(tx_done), .ir_envelope(ir_envelope), .ir_led(ir_led)
  );

  typedef struct {
    logic [15:0] code;
    int          start_cyc;
    int          units;
  } exp_t;

  exp_t sb[$];
  logic run_lvl[$];
  int   run_len[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc_cnt = 0;
  logic cur_lvl;
  int   cur_len, busy_cnt, led_err;
  logic done_prev;

  initial begin
    osc_clk = 1'b0;
    forever #5 osc_clk = ~osc_clk;
  end

  initial forever begin
    @(posedge osc_clk);
    cyc_cnt++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Frame length in NEC units from the protocol rules: leader 16+8, stop 1,
  // each data bit one mark unit plus a 1- or 3-unit space.
  function automatic int frame_units(input logic [15:0] code);
    logic [7:0] bytes [4];
    int u;
    bytes[0] = code[15:8];
    bytes[1] = ~code[15:8];
    bytes[2] = code[7:0];
    bytes[3] = ~code[7:0];
    u = 16 + 8 + 1;
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 8; i++)
        u += 1 + (bytes[b][i] ? 3 : 1);
    return u;
  endfunction

  task automatic check_frame();
    exp_t       e;
    int         base, bad_mark, bad_space;
    logic [31:0] bits;
    logic [7:0] na, nc;
    chk("done_width", int'(done_prev), 0);
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_done: tx_done seen at cycle %0d, expected no frame", cyc_cnt);
    end else begin
      e = sb.pop_front();
      if (run_len.size() < 67) begin
        chk("run_count", run_len.size(), 67);
      end else begin
        base = run_len.size() - 67;
        bad_mark = 0;
        bad_space = 0;
        bits = '0;
        chk("lead_mark", (run_lvl[base] === 1'b1) ? run_len[base] : -1, 16 * U);
        chk("lead_space", (run_lvl[base+1] === 1'b0) ? run_len[base+1] : -1, 8 * U);
        for (int i = 0; i < 32; i++) begin
          if (run_lvl[base+2+2*i] !== 1'b1 || run_len[base+2+2*i] != U) bad_mark++;
          if (run_lvl[base+3+2*i] !== 1'b0) bad_space++;
          else if (run_len[base+3+2*i] == U) bits[i] = 1'b0;
          else if (run_len[base+3+2*i] == 3 * U) bits[i] = 1'b1;
          else bad_space++;
        end
        chk("bit_marks_bad", bad_mark, 0);
        chk("bit_spaces_bad", bad_space, 0);
        chk("stop_mark", (run_lvl[base+66] === 1'b1) ? run_len[base+66] : -1, U);
        na = ~e.code[15:8];
        nc = ~e.code[7:0];
        chk("addr", int'(bits[7:0]), int'(e.code[15:8]));
        chk("addr_n", int'(bits[15:8]), int'(na));
        chk("cmd", int'(bits[23:16]), int'(e.code[7:0]));
        chk("cmd_n", int'(bits[31:24]), int'(nc));
      end
      chk("frame_cycles", cyc_cnt - e.start_cyc, e.units * U);
      chk("busy_cycles", busy_cnt, e.units * U);
      chk("carrier_errs", led_err, 0);
    end
    run_lvl.delete();
    run_len.delete();
    busy_cnt = 0;
    led_err  = 0;
  endtask

  // Monitor: run-length decode of the envelope plus carrier-phase check inside marks.
  initial begin
    int   pos;
    logic exp_led;
    cur_lvl = 1'b0; cur_len = 0; busy_cnt = 0; led_err = 0; done_prev = 1'b0;
    forever begin
      @(negedge osc_clk);
      if (!reset) begin
        run_lvl.delete();
        run_len.delete();
        cur_lvl = 1'b0; cur_len = 0; busy_cnt = 0; led_err = 0; done_prev = 1'b0;
      end else begin
        pos = (ir_envelope === cur_lvl) ? cur_len : 0;
        exp_led = ir_envelope && (((pos / CH) % 2) == 0);
        if (ir_led !== exp_led) led_err++;
        if (ir_envelope === cur_lvl) begin
          cur_len++;
        end else begin
          run_lvl.push_back(cur_lvl);
          run_len.push_back(cur_len);
          cur_lvl = ir_envelope;
          cur_len = 1;
        end
        if (tx_busy) busy_cnt++;
        if (tx_done) check_frame();
        done_prev = tx_done;
      end
    end
  end

  task automatic issue_start(input logic [15:0] code);
    exp_t e;
    tx_data  = code;
    tx_start = 1'b1;
    e.code      = code;
    e.start_cyc = cyc_cnt + 1;
    e.units     = frame_units(code);
    sb.push_back(e);
  endtask

  task automatic wait_done(input bit noise, input bit hold);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 700 && !seen; k++) begin
      @(negedge osc_clk);
      if (tx_done) begin
        seen = 1'b1;
        if (!hold) tx_start = 1'b0;
      end else if (noise) begin
        tx_data  = 16'($urandom);
        tx_start = ($urandom_range(0, 15) == 0);
      end
    end
    if (!hold) tx_start = 1'b0;
    chk("done_seen", int'(seen), 1);
  endtask

  task automatic run_frame(input logic [15:0] code, input int gap, input bit noise);
    repeat (gap) @(negedge osc_clk);
    issue_start(code);
    @(negedge osc_clk);
    tx_start = 1'b0;
    wait_done(noise, 1'b0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, int'(tx_busy), 0);
    chk({tag, "_done"}, int'(tx_done), 0);
    chk({tag, "_env"}, int'(ir_envelope), 0);
    chk({tag, "_led"}, int'(ir_led), 0);
  endtask

  initial begin
    reset    = 1'b0;
    tx_start = 1'b0;
    tx_data  = 16'h0000;
    repeat (3) @(negedge osc_clk);
    chk_quiet("por");
    reset = 1'b1;
    repeat (3) @(negedge osc_clk);
    chk_quiet("idle");

    run_frame(16'h0000, 0, 1'b0);
    run_frame(16'hA55A, 2, 1'b0);

    // Start pulse with different data in the middle of a frame must be ignored.
    issue_start(16'h00FF);
    @(negedge osc_clk);
    tx_start = 1'b0;
    repeat (99) @(negedge osc_clk);
    tx_data  = 16'h1234;
    tx_start = 1'b1;
    @(negedge osc_clk);
    tx_start = 1'b0;
    wait_done(1'b0, 1'b0);

    // Start held high: second frame begins right after the done cycle.
    issue_start(16'h5AC3);
    wait_done(1'b0, 1'b1);
    issue_start(16'h9E21);
    @(negedge osc_clk);
    tx_start = 1'b0;
    chk("b2b_env", int'(ir_envelope), 1);
    chk("b2b_busy", int'(tx_busy), 1);
    wait_done(1'b0, 1'b0);

    // Reset during the first data-bit space.
    issue_start(16'hC3A5);
    @(negedge osc_clk);
    tx_start = 1'b0;
    repeat (101) @(negedge osc_clk);
    #1 reset = 1'b0;
    sb.delete();
    #1 chk_quiet("midrst");
    repeat (3) @(negedge osc_clk);
    reset = 1'b1;
    repeat (5) @(negedge osc_clk);
    chk_quiet("postrst");
    run_frame(16'h3C96, 1, 1'b0);

    for (int f = 0; f < 10; f++)
      run_frame(16'($urandom), int'($urandom_range(0, 4)), f[0]);

    repeat (3) @(negedge osc_clk);
    chk("sb_left", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
